lsu_req: RTL

- Core-side load/store initiator that drives the byte-addressed data memory port.
- Accepts one load/store from the execute stage, checks alignment, and issues a word-aligned request with byte enables and lane-replicated write data.
- Waits for grant and response, then returns load data extracted and sign/zero-extended per func3 to writeback.
- One transaction outstanding; a watchdog converts a missing memory response into a bus error.

---
 rtl/core_pkg.sv | 27 ++
 rtl/lsu_req_if.sv | 23 ++
 rtl/lsu_align.sv | 65 ++++++
 rtl/lsu_req.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: load/store size encodings, LSU state codes and the
// per-access context captured at acceptance.
package core_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] REQ       = 2'd1;
   localparam logic [1:0] WAIT_RESP = 2'd2;
   localparam logic [1:0] RESP      = 2'd3;

   typedef struct packed {
      logic       we;
      logic [1:0] lane;
      logic [2:0] func3;
   } lsu_ctx_t;

   // Byte at little-endian offset lane within a 32-bit word.
   function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] lane);
      return word[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/lsu_req_if.sv
// Byte-addressed data memory port: request/grant handshake plus response channel.
interface lsu_req_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );

endinterface

// File: rtl/lsu_align.sv
// Size/alignment formatter for byte-addressed accesses: byte enables, lane
// replication of store data, load extraction and legality checks.
module lsu_align
   import core_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  func3,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext,
   output logic        misalign,
   output logic        illegal
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = pick_byte(rdata, addr);
   assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      // NOTE: every output gets a default before the case, so no path can infer a latch.
      be        = 4'b0000;
      wdata_rep = wdata;
      rdata_ext = 32'h0;
      misalign  = 1'b0;
      illegal   = 1'b0;
      case (func3)
         F3_B: begin
            be        = 4'b0001 << addr;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{byte_sel[7]}}, byte_sel};
         end
         F3_BU: begin
            be        = 4'b0001 << addr;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {24'h0, byte_sel};
            illegal   = we;
         end
         F3_H: begin
            be        = 4'b0011 << addr;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{half_sel[15]}}, half_sel};
            misalign  = addr[0];
         end
         F3_HU: begin
            be        = 4'b0011 << addr;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {16'h0, half_sel};
            misalign  = addr[0];
            illegal   = we;
         end
         F3_W: begin
            be        = 4'b1111;
            rdata_ext = rdata;
            misalign  = |addr;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/lsu_req.sv
// Single-outstanding load/store initiator: accepts one access from execute,
// drives the data memory port and returns formatted load data or an error.
module lsu_req
   import core_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16   // minimum 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_func3,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misalign,
   output logic        resp_err,
   lsu_req_if.master   mem
);

   localparam int unsigned WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

   logic [1:0]        state_q,    state_d;
   lsu_ctx_t          ctx_q,      ctx_d;
   logic [31:0]       addr_q,     addr_d;
   logic [3:0]        be_q,       be_d;
   logic [31:0]       wdata_q,    wdata_d;
   logic [31:0]       rdata_q,    rdata_d;
   logic              misalign_q, misalign_d;
   logic              err_q,      err_d;
   logic [WDOG_W-1:0] wdog_q,     wdog_d;

   logic        is_idle;
   logic [2:0]  al_func3;
   logic [1:0]  al_addr;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   logic        al_misalign;
   logic        al_illegal;

   // Formatter sees the live request while idle, the captured context afterwards.
   assign is_idle  = (state_q == IDLE);
   assign al_func3 = is_idle ? req_func3     : ctx_q.func3;
   assign al_addr  = is_idle ? req_addr[1:0] : ctx_q.lane;

   lsu_align u_align (
      .we        (req_we),
      .func3     (al_func3),
      .addr      (al_addr),
      .wdata     (req_wdata),
      .rdata     (mem.mem_rdata),
      .be        (al_be),
      .wdata_rep (al_wdata),
      .rdata_ext (al_rdata),
      .misalign  (al_misalign),
      .illegal   (al_illegal)
   );

   always_comb begin
      state_d    = state_q;
      ctx_d      = ctx_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      misalign_d = misalign_q;
      err_d      = err_q;
      wdog_d     = wdog_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               ctx_d      = '{we: req_we, lane: req_addr[1:0], func3: req_func3};
               addr_d     = {req_addr[31:2], 2'b00};
               be_d       = al_be;
               wdata_d    = al_wdata;
               rdata_d    = 32'h0;
               misalign_d = al_misalign;
               err_d      = al_illegal;
               state_d    = (al_misalign || al_illegal) ? RESP : REQ;
            end
         end
         REQ: begin
            if (mem.mem_gnt) begin
               wdog_d = '0;
               if (mem.mem_rvalid) begin
                  rdata_d = ctx_q.we ? 32'h0 : al_rdata;
                  state_d = RESP;
               end else begin
                  state_d = WAIT_RESP;
               end
            end
         end
         WAIT_RESP: begin
            // A response landing on the timeout cycle takes priority over the abort.
            if (mem.mem_rvalid) begin
               rdata_d = ctx_q.we ? 32'h0 : al_rdata;
               state_d = RESP;
            end else if (wdog_q == WDOG_LAST) begin
               rdata_d = 32'h0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         RESP: begin
            rdata_d    = 32'h0;
            misalign_d = 1'b0;
            err_d      = 1'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ctx_q      <= '0;
         addr_q     <= 32'h0;
         be_q       <= 4'b0000;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
         misalign_q <= 1'b0;
         err_q      <= 1'b0;
         wdog_q     <= '0;
      end else begin
         state_q    <= state_d;
         ctx_q      <= ctx_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
         err_q      <= err_d;
         wdog_q     <= wdog_d;
      end
   end

   assign req_ready     = is_idle;
   assign resp_valid    = (state_q == RESP);
   assign resp_rdata    = resp_valid ? rdata_q : 32'h0;
   assign resp_misalign = resp_valid & misalign_q;
   assign resp_err      = resp_valid & err_q;

   assign mem.mem_req   = (state_q == REQ);
   assign mem.mem_we    = ctx_q.we;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_be    = be_q;
   assign mem.mem_wdata = wdata_q;

endmodule
